multicycle_control: RTL and testbench

Multi-cycle control unit that drives the control inputs of the RISC-V datapath, replacing the externally driven testbench signals. It sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK per instruction. It decodes the instruction word presented by the instruction source, and returns PC load/branch-select commands to that source. It sits beside `datapath` at top level and closes the loop that the instruction source opens.

---
 rtl/multicycle_control.sv | 193 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer driving the RISC-V datapath controls.
// Optional branch support is enabled by defining MULTICYCLE_BRANCH_EN; without it opcode 1100011 traps.
module multicycle_control #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic [31:0]            instruction,
    input  logic                   selectedFlag,
    output logic                   loadIR,
    output logic                   loadPC,
    output logic                   pcSrc,
    output logic                   writeEnable_Registers,
    output logic                   writeEnable_DataMemory,
    output logic                   muxSelect_ImmVsDataout2,
    output logic                   muxSelect_SumVsReadData,
    output logic                   SumOrSub,
    output logic                   retired,
    output logic                   trap,
    output logic [COUNT_WIDTH-1:0] instrCount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        C_NONE,
        C_ALU,
        C_ADDI,
        C_LD,
        C_SD,
        C_BR
    } iclass_t;

    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                   state_q, state_d;
    iclass_t                  class_q, class_d;
    logic                     sub_q, sub_d;
    logic [COUNT_WIDTH-1:0]   count_q, count_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    iclass_t    dec_class;
    logic       final_st;
    logic       in_exec_phase;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign funct7 = instruction[31:25];

    // Register fields and immediates belong to the datapath; only the class-selecting bits matter here.
    logic unused_instr_bits;
`ifdef MULTICYCLE_BRANCH_EN
    assign unused_instr_bits = ^{instruction[24:15], instruction[11:7]};
`else
    assign unused_instr_bits = ^{instruction[24:15], instruction[11:7], selectedFlag};
`endif

    always_comb begin
        dec_class = C_NONE;
        case (opcode)
            7'b0110011: begin
                if (funct3 == 3'b000 && (funct7 == 7'b0000000 || funct7 == 7'b0100000)) begin
                    dec_class = C_ALU;
                end
            end
            7'b0010011: begin
                if (funct3 == 3'b000) begin
                    dec_class = C_ADDI;
                end
            end
            7'b0000011: begin
                if (funct3 == 3'b011) begin
                    dec_class = C_LD;
                end
            end
            7'b0100011: begin
                if (funct3 == 3'b011) begin
                    dec_class = C_SD;
                end
            end
`ifdef MULTICYCLE_BRANCH_EN
            7'b1100011: begin
                if (funct3 != 3'b010 && funct3 != 3'b011) begin
                    dec_class = C_BR;
                end
            end
`endif
            default: dec_class = C_NONE;
        endcase
    end

    // The last state of each instruction differs by class: BR ends in EXECUTE, SD in MEMORY.
    assign final_st = (state_q == S_WRITEBACK) ||
                      (state_q == S_MEMORY  && class_q == C_SD) ||
                      (state_q == S_EXECUTE && class_q == C_BR);

    assign in_exec_phase = (state_q == S_EXECUTE) || (state_q == S_MEMORY) ||
                           (state_q == S_WRITEBACK);

    always_comb begin
        state_d = state_q;
        class_d = class_q;
        sub_d   = sub_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                class_d = dec_class;
                sub_d   = (dec_class == C_ALU) && funct7[5];
                state_d = (dec_class == C_NONE) ? S_TRAP : S_EXECUTE;
            end
            S_EXECUTE: begin
                case (class_q)
                    C_ALU, C_ADDI: state_d = S_WRITEBACK;
                    C_LD, C_SD:    state_d = S_MEMORY;
                    default:       state_d = S_EXECUTE;
                endcase
            end
            S_MEMORY: begin
                if (class_q == C_LD) begin
                    state_d = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                state_d = S_WRITEBACK;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (final_st) begin
            count_d = count_q + COUNT_ONE;
            state_d = run ? S_FETCH : S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            class_q <= C_NONE;
            sub_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            sub_q   <= sub_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        loadIR                  = (state_q == S_FETCH);
        loadPC                  = final_st;
        retired                 = final_st;
        writeEnable_Registers   = (state_q == S_WRITEBACK);
        writeEnable_DataMemory  = (state_q == S_MEMORY) && (class_q == C_SD);
        muxSelect_SumVsReadData = (state_q == S_WRITEBACK) && (class_q == C_LD);
        muxSelect_ImmVsDataout2 = in_exec_phase &&
                                  (class_q == C_ADDI || class_q == C_LD || class_q == C_SD);
        SumOrSub                = in_exec_phase &&
                                  ((class_q == C_ALU && sub_q) || class_q == C_BR);
        trap                    = (state_q == S_TRAP);
        instrCount              = count_q;
`ifdef MULTICYCLE_BRANCH_EN
        // Branch condition is only valid during EXECUTE, so it passes straight through.
        pcSrc                   = (state_q == S_EXECUTE) && (class_q == C_BR) && selectedFlag;
`else
        pcSrc                   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    localparam int CW = 8;
`ifdef MULTICYCLE_BRANCH_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          run = 1'b0;
    logic [31:0]   instruction = 32'h0;
    logic          selectedFlag = 1'b0;
    logic          loadIR, loadPC, pcSrc, we_reg, we_dm, mux_imm, mux_rd, sos, retired, trap;
    logic [CW-1:0] instrCount;

    always #5 clk = ~clk;

    multicycle_control #(.COUNT_WIDTH(CW)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .run                    (run),
        .instruction            (instruction),
        .selectedFlag           (selectedFlag),
        .loadIR                 (loadIR),
        .loadPC                 (loadPC),
        .pcSrc                  (pcSrc),
        .writeEnable_Registers  (we_reg),
        .writeEnable_DataMemory (we_dm),
        .muxSelect_ImmVsDataout2(mux_imm),
        .muxSelect_SumVsReadData(mux_rd),
        .SumOrSub               (sos),
        .retired                (retired),
        .trap                   (trap),
        .instrCount             (instrCount)
    );

    int errs = 0;
    int checks = 0;

    // Reference: mode 0 idle, 1 executing, 2 trapped; k = cycle number since FETCH (FETCH = 1).
    int m_mode = 0;
    int m_k = 0;
    int m_len = 0;
    int m_cls = 0;
    bit m_sub = 1'b0;
    int m_count = 0;

    // Class codes: 0 illegal, 1 add/sub, 2 addi, 3 ld, 4 sd, 5 branch.
    function automatic int cls_of(input logic [31:0] w);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        if (op == 7'h33 && f3 == 3'd0 && (f7 == 7'h00 || f7 == 7'h20)) return 1;
        if (op == 7'h13 && f3 == 3'd0) return 2;
        if (op == 7'h03 && f3 == 3'd3) return 3;
        if (op == 7'h23 && f3 == 3'd3) return 4;
        if (BR_EN && op == 7'h63 && f3 != 3'd2 && f3 != 3'd3) return 5;
        return 0;
    endfunction

    function automatic int len_of(input int c);
        case (c)
            1, 2, 4: return 4;
            3:       return 5;
            5:       return 3;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h (mode=%0d k=%0d cls=%0d)",
                   tag, obs, exp, m_mode, m_k, m_cls);
        end
    endtask

    task automatic cycle(input logic r, input logic rn, input logic [31:0] w, input logic f);
        bit busy, inex, fin, wr;
        int c;
        @(negedge clk);
        reset = r;
        run = rn;
        instruction = w;
        selectedFlag = f;
        #1;
        busy = (m_mode == 1);
        inex = busy && m_k >= 3;
        fin  = inex && m_k == m_len;
        wr   = fin && (m_cls == 1 || m_cls == 2 || m_cls == 3);
        check("loadIR",  32'(loadIR),  32'(busy && m_k == 1));
        check("loadPC",  32'(loadPC),  32'(fin));
        check("retired", 32'(retired), 32'(fin));
        check("pcSrc",   32'(pcSrc),   32'(BR_EN && fin && m_cls == 5 && f));
        check("weReg",   32'(we_reg),  32'(wr));
        check("weDM",    32'(we_dm),   32'(inex && m_cls == 4 && m_k == 4));
        check("muxImm",  32'(mux_imm), 32'(inex && (m_cls == 2 || m_cls == 3 || m_cls == 4)));
        check("muxRead", 32'(mux_rd),  32'(wr && m_cls == 3));
        check("sumSub",  32'(sos),     32'(inex && ((m_cls == 1 && m_sub) || m_cls == 5)));
        check("trap",    32'(trap),    32'(m_mode == 2));
        check("count",   32'(instrCount), 32'(m_count));
        @(posedge clk);
        if (r) begin
            m_mode = 0;
            m_k = 0;
            m_count = 0;
            m_cls = 0;
        end else if (m_mode == 0) begin
            if (rn) begin
                m_mode = 1;
                m_k = 1;
            end
        end else if (m_mode == 1) begin
            if (m_k == 2) begin
                c = cls_of(w);
                if (c == 0) begin
                    m_mode = 2;
                end else begin
                    m_cls = c;
                    m_len = len_of(c);
                    m_sub = (c == 1) && w[30];
                    m_k = 3;
                end
            end else if (fin) begin
                m_count = (m_count + 1) % (1 << CW);
                if (rn) m_k = 1;
                else m_mode = 0;
            end else begin
                m_k++;
            end
        end
    endtask

    // Runs one instruction to its final state (or into TRAP, which is then held and cleared by reset).
    // drop > 0 lowers run from cycle number drop onwards.
    task automatic exec(input logic [31:0] w, input logic f, input int drop);
        int n;
        bit done, rn, fin_exp;
        n = 0;
        done = 0;
        while (!done) begin
            rn = !(drop > 0 && m_mode == 1 && m_k >= drop);
            fin_exp = (m_mode == 1 && m_k >= 3 && m_k == m_len);
            cycle(1'b0, rn, w, f);
            n++;
            if (fin_exp || m_mode == 2) begin
                done = 1;
            end else if (n > 12) begin
                checks++;
                errs++;
                $error("FAIL exec_bound observed=%0d expected<=12 word=%h", n, w);
                done = 1;
            end
        end
        if (m_mode == 2) begin
            repeat (12) cycle(1'b0, 1'b1, w, 1'b1);
            cycle(1'b1, 1'b0, 32'h0, 1'b0);
            cycle(1'b0, 1'b0, 32'h0, 1'b0);
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [4:0] rd, rs1, rs2;
        logic [11:0] imm;
        logic [2:0] f3;
        int sel;
        rd = 5'($urandom);
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        imm = 12'($urandom);
        f3 = 3'($urandom);
        sel = $urandom_range(0, 19);
        if (sel <= 3) return {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, rs2, rs1, 3'd0, rd, 7'h33};
        if (sel <= 6) return {imm, rs1, 3'd0, rd, 7'h13};
        if (sel <= 9) return {imm, rs1, 3'd3, rd, 7'h03};
        if (sel <= 12) return {imm[11:5], rs2, rs1, 3'd3, imm[4:0], 7'h23};
        if (sel <= 16) begin
            if (f3 == 3'd2 || f3 == 3'd3) f3 = 3'd0;
            return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h63};
        end
        if (sel == 17) return {7'($urandom_range(0, 3)), rs2, rs1, f3, rd, 7'h33};
        if (sel == 18) return {imm, rs1, f3, rd, 7'h03};
        return $urandom;
    endfunction

    initial begin
        int n;
        logic [31:0] w;
        reset = 1'b1;
        @(posedge clk);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b1, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);

        exec(32'h002081B3, 1'b0, 0);
        exec(32'h0080B283, 1'b0, 0);
        exec(32'h0050B823, 1'b1, 0);
        exec(32'h00208463, 1'b1, 0);
        exec(32'h00208463, 1'b0, 0);
        exec(32'h40208233, 1'b0, 3);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        exec(32'h00508093, 1'b0, 0);
        exec(32'h00000000, 1'b0, 0);

        n = 0;
        while (!(m_mode == 1 && m_k == 4) && n < 12) begin
            cycle(1'b0, 1'b1, 32'h002081B3, 1'b0);
            n++;
        end
        check("reach_wb", 32'(m_mode == 1 && m_k == 4), 32'd1);
        cycle(1'b1, 1'b1, 32'h002081B3, 1'b0);
        cycle(1'b0, 1'b0, 32'h002081B3, 1'b0);
        cycle(1'b0, 1'b0, 32'h002081B3, 1'b0);

        for (int i = 0; i < 320; i++) begin
            w = rand_word();
            exec(w, 1'($urandom), ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 5)) : 0);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
